// File: rtl/sa_matmul_engine.sv
// Streaming signed matrix multiply: loads X (T x DIM) and W (DIM x DIM), then emits
// Y = X*W or X*W^T one element per cycle through DIM multipliers and an adder tree.
module sa_matmul_engine #(
    parameter  int DW   = 8,
    parameter  int DIM  = 8,
    parameter  int TMAX = 8,
    parameter  int OW   = 2*DW + $clog2(DIM),
    localparam int TW   = $clog2(TMAX+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cg_en,
    input  logic                 in_valid,
    input  logic [TW-1:0]        T,
    input  logic                 tr,
    input  logic signed [DW-1:0] in_data,
    input  logic signed [DW-1:0] w,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data
);
    localparam int KW = $clog2(DIM);
    localparam int XW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int LW = 2*KW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;
    state_t r_state, w_next;

    logic [TW-1:0]        r_t;
    logic                 r_tr;
    logic [LW-1:0]        r_lcnt;
    logic signed [DW-1:0] r_x [TMAX][DIM];
    logic signed [DW-1:0] r_w [DIM][DIM];
    logic [XW-1:0]        r_ci;
    logic [KW-1:0]        r_cj;
    logic                 r_idone;
    logic                 r_sv;
    logic signed [OW-1:0] r_sum;

    logic                 w_ld, w_issue;
    logic [TW-1:0]        w_tclamp, w_teff;
    logic [KW-1:0]        w_row, w_col;
    logic [XW-1:0]        w_xrow;

    assign w_tclamp = (T == '0 || int'(T) > TMAX) ? TW'(TMAX) : T;
    assign w_teff   = (r_state == S_IDLE) ? w_tclamp : r_t;
    assign w_row    = r_lcnt[LW-1:KW];
    assign w_col    = r_lcnt[KW-1:0];
    assign w_xrow   = XW'(w_row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_LOAD;
            S_LOAD:  if (in_valid && r_lcnt == LW'(DIM*DIM-1)) w_next = S_CALC;
            S_CALC:  w_next = S_OUT;
            S_OUT:   if (out_valid && !r_sv) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ld    = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            S_IDLE, S_LOAD: w_ld    = in_valid;
            S_CALC:         w_issue = 1'b1;
            S_OUT:          w_issue = !r_idone;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t    <= '0;
            r_tr   <= 1'b0;
            r_lcnt <= '0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_t  <= w_tclamp;
                r_tr <= tr;
            end
            if (w_ld) r_lcnt <= r_lcnt + 1'b1;
        end
    end

    // X beyond row T is don't-care on the bus and never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TMAX; i++)
                for (int k = 0; k < DIM; k++) r_x[i][k] <= '0;
            for (int i = 0; i < DIM; i++)
                for (int k = 0; k < DIM; k++) r_w[i][k] <= '0;
        end else if (w_ld) begin
            r_w[w_row][w_col] <= w;
            if (int'(w_row) < int'(w_teff)) r_x[w_xrow][w_col] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ci    <= '0;
            r_cj    <= '0;
            r_idone <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_ci    <= '0;
            r_cj    <= '0;
            r_idone <= 1'b0;
        end else if (w_issue) begin
            r_cj <= r_cj + 1'b1;
            if (r_cj == KW'(DIM-1)) begin
                r_ci <= r_ci + 1'b1;
                if (int'(r_ci) == int'(r_t) - 1) r_idone <= 1'b1;
            end
        end
    end

    logic signed [2*DW-1:0] w_prod [DIM];
    logic signed [OW-1:0]   w_node [2*DIM-1];

    genvar g;
    for (g = 0; g < DIM; g++) begin : g_lane
        logic signed [DW-1:0] w_b;
        assign w_b                 = r_tr ? r_w[r_cj][g] : r_w[g][r_cj];
        assign w_prod[g]           = (2*DW)'(r_x[r_ci][g]) * (2*DW)'(w_b);
        assign w_node[DIM-1+g]     = OW'(w_prod[g]);
    end
    // heap-ordered tree: node n sums children 2n+1 and 2n+2, root is node 0
    for (g = 0; g < DIM-1; g++) begin : g_tree
        assign w_node[g] = w_node[2*g+1] + w_node[2*g+2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sv      <= 1'b0;
            r_sum     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            r_sv <= w_issue;
            if (w_issue || !cg_en) r_sum <= w_node[0];
            out_valid <= r_sv;
            out_data  <= r_sv ? r_sum : '0;
        end
    end
endmodule

// File: tb/tb_sa_matmul_engine.sv
// Directed bench for sa_matmul_engine: table of jobs with hand-computed results,
// plus sequences for illegal in_valid, mid-output reset and cg_en equivalence.
module tb_sa_matmul_engine;
    localparam int DW = 8, DIM = 8, TMAX = 8, OW = 19, TW = 4;

    logic                 clk = 1'b0, rst_n = 1'b0, cg_en = 1'b0, in_valid = 1'b0, tr = 1'b0;
    logic [TW-1:0]        T = '0;
    logic signed [DW-1:0] in_data = '0, w = '0;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;

    sa_matmul_engine #(.DW(DW), .DIM(DIM), .TMAX(TMAX), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .cg_en(cg_en), .in_valid(in_valid), .T(T), .tr(tr),
        .in_data(in_data), .w(w), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int gx[8][8], gw[8][8];
    int outs[$];
    int trace[$];
    bit tracing = 1'b0;

    typedef struct {
        int t; int trm; int xm; int wm; int cnt; int y0; int ylast;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pat_x(int m, int i, int k, int s);
        case (m)
            0:       return i*8 + k - 32;
            1:       return 1;
            2:       return -128;
            3:       return i - k;
            default: return ((i*37 + k*11 + s*13) % 256) - 128;
        endcase
    endfunction

    function automatic int pat_w(int m, int k, int j, int s);
        case (m)
            0:       return (k == j) ? 1 : 0;
            1:       return k;
            2:       return -128;
            3:       return 127;
            default: return ((k*29 + j*5 + s*17 + 3) % 256) - 128;
        endcase
    endfunction

    task automatic run_job(input int t, input int trm, input int xm, input int wm, input int s,
                           input int ill, input int rst_at, output int n);
        int teff, lat, e;
        bit was_rst;
        teff = (t == 0 || t > 8) ? 8 : t;
        was_rst = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                gx[i][k] = pat_x(xm, i, k, s);
                gw[i][k] = pat_w(wm, i, k, s);
            end
        outs.delete();
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            T        = (c == 0) ? TW'(t) : TW'(t + 3);
            tr       = (c == 0) ? trm[0] : ~trm[0];
            in_data  = (c < teff*8) ? DW'(gx[c/8][c%8]) : 8'sd99;
            w        = DW'(gw[c/8][c%8]);
        end
        @(negedge clk);
        in_valid = 1'b0; in_data = '0; w = '0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            chk("idle_data_zero", int'(out_data), 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
        n = 0;
        while (out_valid && n < 100) begin
            outs.push_back(int'(out_data));
            if (tracing) trace.push_back(int'(out_data));
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_out_data", int'(out_data), 0);
                in_valid = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                was_rst = 1'b1;
                break;
            end
            in_valid = (ill != 0 && n >= 5 && n < 10);
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!was_rst) begin
            chk("tail_data_zero", int'(out_data), 0);
            for (int q = 0; q < n && q < teff*8; q++) begin
                e = 0;
                for (int k = 0; k < 8; k++)
                    e += gx[q/8][k] * ((trm != 0) ? gw[q%8][k] : gw[k][q%8]);
                chk($sformatf("y[%0d][%0d]", q/8, q%8), outs[q], e);
            end
        end
    endtask

    initial begin
        int n;
        int tr0[$];
        vecs[0] = '{8, 0, 0, 0, 64,    -32,     31};
        vecs[1] = '{3, 1, 1, 1, 24,      0,     56};
        vecs[2] = '{3, 0, 1, 1, 24,     28,     28};
        vecs[3] = '{8, 0, 2, 2, 64, 131072, 131072};
        vecs[4] = '{8, 0, 2, 3, 64,-130048,-130048};
        vecs[5] = '{1, 0, 0, 0,  8,    -32,    -25};
        vecs[6] = '{0, 0, 0, 0, 64,    -32,     31};
        vecs[7] = '{9, 1, 0, 0, 64,    -32,     31};
        vecs[8] = '{2, 0, 3, 1, 16,   -140,   -112};
        vecs[9] = '{8, 1, 3, 1, 64,      0,    196};

        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) begin
            run_job(vecs[v].t, vecs[v].trm, vecs[v].xm, vecs[v].wm, 0, 0, -1, n);
            chk($sformatf("vec%0d_count", v), n, vecs[v].cnt);
            if (n > 0) begin
                chk($sformatf("vec%0d_first", v), outs[0], vecs[v].y0);
                chk($sformatf("vec%0d_last", v), outs[n-1], vecs[v].ylast);
            end
        end

        // in_valid pulses during OUT must not disturb the job
        run_job(4, 0, 0, 0, 0, 1, -1, n);
        chk("illegal_in_valid_count", n, 32);

        // reset at output index 20, then a fresh job
        run_job(8, 0, 0, 0, 0, 0, 20, n);
        chk("after_rst_idle", int'(out_valid), 0);
        run_job(3, 0, 3, 1, 0, 0, -1, n);
        chk("post_rst_count", n, 24);
        if (n > 0) chk("post_rst_first", outs[0], -140);

        // cg_en equivalence on a pseudo-random job set
        for (int pass = 0; pass < 2; pass++) begin
            int ts[4] = '{5, 2, 8, 7};
            cg_en = pass[0];
            trace.delete();
            tracing = 1'b1;
            for (int j = 0; j < 4; j++) begin
                run_job(ts[j], j % 2, 4, 4, j + 1, 0, -1, n);
                chk($sformatf("cg%0d_job%0d_count", pass, j), n, ts[j]*8);
            end
            tracing = 1'b0;
            if (pass == 0) tr0 = trace;
        end
        chk("cg_trace_len", trace.size(), tr0.size());
        begin
            int diffs = 0;
            for (int q = 0; q < trace.size() && q < tr0.size(); q++)
                if (trace[q] != tr0[q]) diffs++;
            chk("cg_trace_diffs", diffs, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
